// File: rtl/regfile_read_port.sv
// Read side of the 8 x 16-bit register file: resolves two operands per request
// (r0 = 0, same-edge write bypass) and returns them in order through a small buffer.
module regfile_read_port #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int SEL_W  = 3,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [(NREG-1)*DATA_W-1:0]   REGS_FLAT,
   input  logic                         WR_EN,
   input  logic [SEL_W-1:0]             WR_SEL,
   input  logic [DATA_W-1:0]            WR_DATA,
   input  logic                         REQ_VALID,
   output logic                         REQ_READY,
   input  logic [SEL_W-1:0]             REQ_SA,
   input  logic [SEL_W-1:0]             REQ_SB,
   input  logic [TAG_W-1:0]             REQ_TAG,
   output logic                         RSP_VALID,
   input  logic                         RSP_READY,
   output logic [DATA_W-1:0]            RSP_A,
   output logic [DATA_W-1:0]            RSP_B,
   output logic [TAG_W-1:0]             RSP_TAG,
   output logic [$clog2(DEPTH):0]       COUNT
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Handshake rule for both ports: a transfer happens on a rising edge where
   // VALID and READY are both high; VALID never waits on READY.

   logic [DATA_W-1:0] r_mem_a   [DEPTH];
   logic [DATA_W-1:0] r_mem_b   [DEPTH];
   logic [TAG_W-1:0]  r_mem_tag [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_rsp_a;
   logic [DATA_W-1:0] r_rsp_b;
   logic [TAG_W-1:0]  r_rsp_tag;

   logic              w_acc;
   logic              w_pop;
   logic              w_head_new;
   logic [PTR_W-1:0]  w_rd_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

   // Bypass makes the snapshot equal to what the array holds after this edge.
   function automatic logic [DATA_W-1:0] f_operand(
      input logic [SEL_W-1:0]             sel,
      input logic                         wr_en,
      input logic [SEL_W-1:0]             wr_sel,
      input logic [DATA_W-1:0]            wr_data,
      input logic [(NREG-1)*DATA_W-1:0]   regs
   );
      logic [DATA_W-1:0] v;
      v = '0;
      if (sel == '0)
         v = '0;
      else if (wr_en && (wr_sel == sel))
         v = wr_data;
      else
         v = regs[(int'(sel) - 1) * DATA_W +: DATA_W];
      return v;
   endfunction

   assign REQ_READY = !RST && ((r_count < DEPTH_C) || RSP_READY);
   assign RSP_VALID = (r_count != '0);
   assign w_acc     = REQ_VALID && REQ_READY;
   assign w_pop     = RSP_VALID && RSP_READY;
   assign w_op_a    = f_operand(REQ_SA, WR_EN, WR_SEL, WR_DATA, REGS_FLAT);
   assign w_op_b    = f_operand(REQ_SB, WR_EN, WR_SEL, WR_DATA, REGS_FLAT);
   assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);
   // The incoming entry becomes the head when nothing older survives this edge.
   assign w_head_new = w_acc && (r_count == CNT_W'(w_pop));

   always_comb begin
      w_cnt_next = r_count;
      if (w_acc && !w_pop)
         w_cnt_next = r_count + CNT_W'(1);
      else if (!w_acc && w_pop)
         w_cnt_next = r_count - CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (w_acc && !RST) begin
         r_mem_a[r_wr_ptr]   <= w_op_a;
         r_mem_b[r_wr_ptr]   <= w_op_b;
         r_mem_tag[r_wr_ptr] <= REQ_TAG;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rsp_a   <= '0;
         r_rsp_b   <= '0;
         r_rsp_tag <= '0;
      end else begin
         if (w_acc)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_rd_ptr <= w_rd_next;
         r_count  <= w_cnt_next;
         // Output registers track the post-edge head; when empty they keep the last pop.
         if (w_cnt_next != '0) begin
            if (w_head_new) begin
               r_rsp_a   <= w_op_a;
               r_rsp_b   <= w_op_b;
               r_rsp_tag <= REQ_TAG;
            end else begin
               r_rsp_a   <= r_mem_a[w_rd_next];
               r_rsp_b   <= r_mem_b[w_rd_next];
               r_rsp_tag <= r_mem_tag[w_rd_next];
            end
         end
      end
   end

   assign RSP_A   = r_rsp_a;
   assign RSP_B   = r_rsp_b;
   assign RSP_TAG = r_rsp_tag;
   assign COUNT   = r_count;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios plus a randomized run, all
// checked against a queue-based model of the in-order response buffer.
module tb_regfile_read_port;

   localparam int DW    = 16;
   localparam int NREG  = 8;
   localparam int SW    = 3;
   localparam int TW    = 4;
   localparam int DEPTH = 2;
   localparam int EW    = 2*DW + TW;

   logic                    clk;
   logic                    rst;
   logic [(NREG-1)*DW-1:0]  regs_flat;
   logic                    wr_en;
   logic [SW-1:0]           wr_sel;
   logic [DW-1:0]           wr_data;
   logic                    req_valid;
   logic                    req_ready;
   logic [SW-1:0]           req_sa;
   logic [SW-1:0]           req_sb;
   logic [TW-1:0]           req_tag;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DW-1:0]           rsp_a;
   logic [DW-1:0]           rsp_b;
   logic [TW-1:0]           rsp_tag;
   logic [1:0]              count;

   logic [DW-1:0] regs [NREG];
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_rsp;
   int            n_cmp;
   int            n_fail;

   regfile_read_port #(.DATA_W(DW), .NREG(NREG), .SEL_W(SW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST(rst), .REGS_FLAT(regs_flat),
      .WR_EN(wr_en), .WR_SEL(wr_sel), .WR_DATA(wr_data),
      .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_SA(req_sa), .REQ_SB(req_sb), .REQ_TAG(req_tag),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
      .RSP_A(rsp_a), .RSP_B(rsp_b), .RSP_TAG(rsp_tag), .COUNT(count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The bench owns the architectural array and presents it flattened.
   always_comb begin
      regs_flat = '0;
      for (int k = 1; k < NREG; k++) regs_flat[(k-1)*DW +: DW] = regs[k];
   end

   // reference model
   function automatic logic [DW-1:0] resolve(input logic [SW-1:0] sel);
      if (sel == 0) return '0;
      if (wr_en && wr_sel == sel) return wr_data;
      return regs[sel];
   endfunction

   function automatic logic [EW-1:0] exp_head();
      return (exp_q.size() != 0) ? exp_q[0] : last_rsp;
   endfunction

   function automatic logic exp_ready();
      return !rst && ((exp_q.size() < DEPTH) || rsp_ready);
   endfunction

   // driver: one clock edge, model advanced with the pre-edge inputs
   task automatic cycle();
      logic          m_acc;
      logic          m_pop;
      logic [EW-1:0] ent;
      m_acc = req_valid && exp_ready();
      m_pop = (exp_q.size() != 0) && rsp_ready;
      ent   = {resolve(req_sa), resolve(req_sb), req_tag};
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         last_rsp = '0;
      end else begin
         if (m_pop) last_rsp = exp_q.pop_front();
         if (m_acc) exp_q.push_back(ent);
      end
      if (wr_en && wr_sel != 0) regs[wr_sel] = wr_data;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
      req_sa = 3'd1; req_sb = 3'd2; req_tag = 4'd15;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      cycle();
      cycle();
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_held: got %b want 0", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if ({rsp_a, rsp_b, rsp_tag} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h/%h want 0/0/0", rsp_a, rsp_b, rsp_tag); end
      rst = 1'b0; req_valid = 1'b0;
      cycle();
   endtask

   task automatic test_basic();
      regs[3] = 16'h1234; regs[5] = 16'hBEEF;
      req_valid = 1'b1; req_sa = 3'd3; req_sb = 3'd5; req_tag = 4'd7; rsp_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_req_ready: got %b want 1", req_ready); end
      cycle();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: rsp_valid got %b want 1", rsp_valid); end
      n_cmp++; if ({rsp_a, rsp_b, rsp_tag} !== {16'h1234, 16'hBEEF, 4'd7}) begin n_fail++; $display("FAIL basic_data: got %h/%h/%h want 1234/beef/7", rsp_a, rsp_b, rsp_tag); end
      cycle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: rsp_valid got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_a !== 16'h1234) begin n_fail++; $display("FAIL basic_hold_last: rsp_a got %h want 1234", rsp_a); end
   endtask

   task automatic test_reg0();
      req_valid = 1'b1; req_sa = 3'd0; req_sb = 3'd0; req_tag = 4'd8;
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
      cycle();
      req_valid = 1'b0; wr_en = 1'b0;
      n_cmp++; if ({rsp_valid, rsp_a, rsp_b, rsp_tag} !== {1'b1, 16'h0000, 16'h0000, 4'd8}) begin n_fail++; $display("FAIL reg0: got v=%b %h/%h/%h want 1 0000/0000/8", rsp_valid, rsp_a, rsp_b, rsp_tag); end
      cycle();
   endtask

   task automatic test_bypass();
      regs[1] = 16'h0042; regs[2] = 16'h1111;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_sa = 3'd2; req_sb = 3'd1; req_tag = 4'd9;
      wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'hA5A5;
      cycle();
      req_valid = 1'b0; wr_data = 16'h5555;
      n_cmp++; if ({rsp_a, rsp_b} !== {16'hA5A5, 16'h0042}) begin n_fail++; $display("FAIL bypass: got %h/%h want a5a5/0042", rsp_a, rsp_b); end
      cycle();
      wr_en = 1'b0;
      n_cmp++; if ({count, rsp_a, rsp_b, rsp_tag} !== {2'd1, 16'hA5A5, 16'h0042, 4'd9}) begin n_fail++; $display("FAIL bypass_snapshot: got cnt=%0d %h/%h/%h want 1 a5a5/0042/9", count, rsp_a, rsp_b, rsp_tag); end
      rsp_ready = 1'b1;
      cycle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_drain: rsp_valid got %b want 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] a_hold;
      rsp_ready = 1'b0; req_valid = 1'b1; req_sa = 3'd3; req_sb = 3'd5;
      req_tag = 4'd1; cycle();
      req_tag = 4'd2; cycle();
      req_tag = 4'd3;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", req_ready); end
      cycle();
      n_cmp++; if ({count, rsp_tag} !== {2'd2, 4'd1}) begin n_fail++; $display("FAIL bp_full: got cnt=%0d tag=%0d want 2/1", count, rsp_tag); end
      n_cmp++; if ({rsp_a, rsp_b, rsp_tag} !== exp_head()) begin n_fail++; $display("FAIL bp_head_data: got %h/%h/%h want %h", rsp_a, rsp_b, rsp_tag, exp_head()); end
      a_hold = rsp_a;
      cycle();
      n_cmp++; if ({rsp_valid, rsp_tag, rsp_a} !== {1'b1, 4'd1, a_hold}) begin n_fail++; $display("FAIL bp_stable: got v=%b tag=%0d a=%h want 1/1/%h", rsp_valid, rsp_tag, rsp_a, a_hold); end
      rsp_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_pop_ready: got %b want 1", req_ready); end
      cycle();
      req_valid = 1'b0;
      n_cmp++; if ({count, rsp_tag} !== {2'd2, 4'd2}) begin n_fail++; $display("FAIL bp_accept_and_pop: got cnt=%0d tag=%0d want 2/2", count, rsp_tag); end
      cycle();
      n_cmp++; if ({count, rsp_tag} !== {2'd1, 4'd3}) begin n_fail++; $display("FAIL bp_order3: got cnt=%0d tag=%0d want 1/3", count, rsp_tag); end
      cycle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: rsp_valid got %b want 0", rsp_valid); end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0; req_valid = 1'b1; req_sa = 3'd3; req_sb = 3'd5;
      req_tag = 4'd4; cycle();
      req_tag = 4'd5; cycle();
      n_cmp++; if (count !== 2'd2) begin n_fail++; $display("FAIL rstmid_fill: count got %0d want 2", count); end
      rst = 1'b1; req_valid = 1'b0;
      cycle();
      rst = 1'b0;
      n_cmp++; if ({count, rsp_valid, rsp_tag} !== {2'd0, 1'b0, 4'd0}) begin n_fail++; $display("FAIL rstmid_clear: got cnt=%0d v=%b tag=%0d want 0/0/0", count, rsp_valid, rsp_tag); end
      rsp_ready = 1'b1; req_valid = 1'b1; req_tag = 4'd6;
      cycle();
      req_valid = 1'b0;
      n_cmp++; if ({rsp_valid, rsp_tag, rsp_a, rsp_b} !== {1'b1, 4'd6, regs[3], regs[5]}) begin n_fail++; $display("FAIL rstmid_new: got v=%b tag=%0d %h/%h want 1/6 %h/%h", rsp_valid, rsp_tag, rsp_a, rsp_b, regs[3], regs[5]); end
      cycle();
      n_cmp++; if ({rsp_valid, rsp_tag} !== {1'b0, 4'd6}) begin n_fail++; $display("FAIL rstmid_drain: got v=%b tag=%0d want 0/6", rsp_valid, rsp_tag); end
   endtask

   task automatic test_random();
      for (int k = 1; k < NREG; k++) regs[k] = DW'($urandom);
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 79) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_sel    = SW'($urandom_range(0, NREG-1));
         wr_data   = DW'($urandom);
         req_sa    = ($urandom_range(0, 3) == 0) ? wr_sel : SW'($urandom_range(0, NREG-1));
         req_sb    = ($urandom_range(0, 4) == 0) ? req_sa : SW'($urandom_range(0, NREG-1));
         req_tag   = TW'($urandom);
         #1;
         n_cmp++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_req_ready[%0d]: got %b want %b", i, req_ready, exp_ready()); end
         cycle();
         n_cmp++; if (count !== 2'(exp_q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, exp_q.size()); end
         n_cmp++; if (rsp_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", i, rsp_valid, exp_q.size() != 0); end
         n_cmp++; if ({rsp_a, rsp_b, rsp_tag} !== exp_head()) begin n_fail++; $display("FAIL rand_head[%0d]: got %h/%h/%h want %h", i, rsp_a, rsp_b, rsp_tag, exp_head()); end
      end
      rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
      cycle();
      cycle();
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      last_rsp = '0;
      for (int k = 0; k < NREG; k++) regs[k] = '0;
      rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      req_valid = 1'b0; req_sa = '0; req_sb = '0; req_tag = '0; rsp_ready = 1'b0;
      test_reset();
      test_basic();
      test_reg0();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
